// File: rtl/lab4_pkg.sv
// Shared constants and state encodings for the lab4 answer transmitter.
// ASCII codes, formatter/serializer state types and the default oversample rate.
package lab4_pkg;

   localparam int OVERSAMPLE_DEFAULT = 16;

   localparam logic [7:0] PLUS  = 8'h2B;
   localparam logic [7:0] MINUS = 8'h2D;
   localparam logic [7:0] ZERO  = 8'h30;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;

   typedef enum logic [2:0] {
      FMT_IDLE,
      FMT_SIGN,
      FMT_TENS,
      FMT_ONES,
      FMT_CR,
      FMT_LF
   } fmt_state_t;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_START,
      SER_DATA,
      SER_STOP
   } ser_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer paced by a 16x-baud strobe.
// A load offered on the stop bit's last tick chains straight into the next start bit.
module uart_tx_byte
   import lab4_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
)
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       tick16,
   input  logic       load,
   input  logic [7:0] din,
   output logic       ready,
   output logic       byte_done,
   output logic       TXD
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

   ser_state_t    r_state, w_state_next;
   logic [TW-1:0] r_tick_cnt, w_tick_cnt_next;
   logic [2:0]    r_bit_cnt, w_bit_cnt_next;
   logic [7:0]    r_shift, w_shift_next;
   logic          r_txd, w_txd_next;
   logic          w_bit_end;

   assign w_bit_end = (r_state != SER_IDLE) && tick16 && (r_tick_cnt == TICK_LAST);
   assign byte_done = (r_state == SER_STOP) && w_bit_end;
   assign ready     = (r_state == SER_IDLE);
   assign TXD       = r_txd;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= SER_IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_txd      <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_tick_cnt <= w_tick_cnt_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_shift    <= w_shift_next;
         r_txd      <= w_txd_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_tick_cnt_next = r_tick_cnt;
      w_bit_cnt_next  = r_bit_cnt;
      w_shift_next    = r_shift;
      w_txd_next      = r_txd;
      if ((r_state != SER_IDLE) && tick16)
         w_tick_cnt_next = w_bit_end ? '0 : r_tick_cnt + 1'b1;
      case (r_state)
         SER_IDLE: begin
            if (load) begin
               w_state_next    = SER_START;
               w_tick_cnt_next = '0;
               w_shift_next    = din;
               w_txd_next      = 1'b0;
            end
         end
         SER_START: begin
            if (w_bit_end) begin
               w_state_next   = SER_DATA;
               w_bit_cnt_next = '0;
               w_txd_next     = r_shift[0];
               w_shift_next   = {1'b0, r_shift[7:1]};
            end
         end
         SER_DATA: begin
            if (w_bit_end) begin
               if (r_bit_cnt == 3'd7) begin
                  w_state_next = SER_STOP;
                  w_txd_next   = 1'b1;
               end else begin
                  w_bit_cnt_next = r_bit_cnt + 3'd1;
                  w_txd_next     = r_shift[0];
                  w_shift_next   = {1'b0, r_shift[7:1]};
               end
            end
         end
         SER_STOP: begin
            if (w_bit_end) begin
               if (load) begin
                  w_state_next    = SER_START;
                  w_tick_cnt_next = '0;
                  w_shift_next    = din;
                  w_txd_next      = 1'b0;
               end else begin
                  w_state_next = SER_IDLE;
                  w_txd_next   = 1'b1;
               end
            end
         end
         default: w_state_next = SER_IDLE;
      endcase
   end

endmodule

// File: rtl/lab4_answer_tx.sv
// Formats the signed lab4 sum as "<sign><tens><ones>\r\n" and sends it over UART.
// The first byte is loaded on the accept edge so the start bit follows immediately.
module lab4_answer_tx
   import lab4_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
   parameter int SUM_W      = 6
)
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             tick16,
   input  logic             start,
   input  logic [SUM_W-1:0] sum,
   output logic             busy,
   output logic             done,
   output logic             TXD
);

   fmt_state_t       r_state, w_state_next;
   logic             r_neg;
   logic [1:0]       r_tens;
   logic [3:0]       r_ones;
   logic             w_neg;
   logic [SUM_W-1:0] w_mag;
   logic [1:0]       w_tens;
   logic [3:0]       w_ones;
   logic             w_accept, w_done, w_load, w_ser_ready, w_byte_done;
   logic [7:0]       w_din;

   assign w_neg = sum[SUM_W-1];
   assign w_mag = w_neg ? (~sum + 1'b1) : sum;

   // Decimal split by subtracting the largest fitting multiple of ten
   always_comb begin
      w_tens = 2'd0;
      w_ones = 4'(w_mag);
      if (w_mag >= SUM_W'(30)) begin
         w_tens = 2'd3;
         w_ones = 4'(w_mag - SUM_W'(30));
      end else if (w_mag >= SUM_W'(20)) begin
         w_tens = 2'd2;
         w_ones = 4'(w_mag - SUM_W'(20));
      end else if (w_mag >= SUM_W'(10)) begin
         w_tens = 2'd1;
         w_ones = 4'(w_mag - SUM_W'(10));
      end
   end

   assign w_done   = (r_state == FMT_LF) && w_byte_done;
   assign busy     = (r_state != FMT_IDLE) && !w_done;
   assign done     = w_done;
   assign w_accept = start && !RST && !busy && (w_ser_ready || w_done);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= FMT_IDLE;
         r_neg   <= 1'b0;
         r_tens  <= '0;
         r_ones  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_neg  <= w_neg;
            r_tens <= w_tens;
            r_ones <= w_ones;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_din        = PLUS;
      case (r_state)
         FMT_IDLE: begin
            if (w_accept) begin
               w_state_next = FMT_SIGN;
               w_load       = 1'b1;
               w_din        = w_neg ? MINUS : PLUS;
            end
         end
         FMT_SIGN: begin
            if (w_byte_done) begin
               w_state_next = FMT_TENS;
               w_load       = 1'b1;
               w_din        = ZERO + 8'(r_tens);
            end
         end
         FMT_TENS: begin
            if (w_byte_done) begin
               w_state_next = FMT_ONES;
               w_load       = 1'b1;
               w_din        = ZERO + 8'(r_ones);
            end
         end
         FMT_ONES: begin
            if (w_byte_done) begin
               w_state_next = FMT_CR;
               w_load       = 1'b1;
               w_din        = CR;
            end
         end
         FMT_CR: begin
            if (w_byte_done) begin
               w_state_next = FMT_LF;
               w_load       = 1'b1;
               w_din        = LF;
            end
         end
         FMT_LF: begin
            if (w_byte_done) begin
               if (w_accept) begin
                  w_state_next = FMT_SIGN;
                  w_load       = 1'b1;
                  w_din        = w_neg ? MINUS : PLUS;
               end else begin
                  w_state_next = FMT_IDLE;
               end
            end
         end
         default: w_state_next = FMT_IDLE;
      endcase
   end

   uart_tx_byte #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_ser (
      .CLK      (CLK),
      .RST      (RST),
      .tick16   (tick16),
      .load     (w_load),
      .din      (w_din),
      .ready    (w_ser_ready),
      .byte_done(w_byte_done),
      .TXD      (TXD)
   );

endmodule

// File: tb/tb_lab4_answer_tx.sv
// Directed bench for lab4_answer_tx: traces each message per cycle and decodes TXD
// with an independent tick-counting UART receiver.
module tb_lab4_answer_tx;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       tick16 = 1'b0;
   logic       start = 1'b0;
   logic [5:0] sum = 6'd0;
   logic       busy, done, TXD;

   lab4_answer_tx #(.OVERSAMPLE(16), .SUM_W(6)) dut (
      .CLK(CLK), .RST(RST), .tick16(tick16), .start(start), .sum(sum),
      .busy(busy), .done(done), .TXD(TXD)
   );

   initial forever #5 CLK = ~CLK;

   int cyc = 0;
   initial forever begin
      @(posedge CLK);
      cyc = cyc + 1;
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   localparam int TR_N = 3400;
   logic tr_txd  [0:TR_N-1];
   logic tr_busy [0:TR_N-1];
   int   done_off, n_done, t0;

   logic [7:0] rx_q[$];
   int         rx_ferr = 0;

   // Receiver: samples each bit on its 8th tick, counting from the start-bit edge
   initial begin : rx_mon
      bit         rx_act;
      int         rx_cnt;
      logic [7:0] rx_sh;
      rx_act = 1'b0;
      rx_cnt = 0;
      rx_sh  = 8'h00;
      forever begin
         @(negedge CLK);
         if (RST) begin
            rx_act = 1'b0;
         end else begin
            if (!rx_act && TXD === 1'b0) begin
               rx_act = 1'b1;
               rx_cnt = 0;
            end
            if (rx_act && tick16) begin
               rx_cnt++;
               if (rx_cnt % 16 == 8) begin
                  if (rx_cnt / 16 == 0) begin
                     if (TXD !== 1'b0) rx_ferr++;
                  end else if (rx_cnt / 16 <= 8) begin
                     rx_sh[rx_cnt / 16 - 1] = TXD;
                  end else begin
                     if (TXD !== 1'b1) rx_ferr++;
                     rx_q.push_back(rx_sh);
                     rx_act = 1'b0;
                  end
               end
            end
         end
      end
   end

   function automatic logic [39:0] pack5(input int base);
      logic [39:0] v;
      v = 40'h0;
      for (int i = 0; i < 5; i++)
         v = {v[31:0], (base + i < rx_q.size()) ? rx_q[base + i] : 8'hEE};
      return v;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
         tick16 = 1'b1;
         start  = 1'b0;
      end
   endtask

   // Offset 0 is the cycle start is driven; trace entry k is sampled mid-cycle t0+k
   task automatic run_msg(input logic [5:0] s, input int div, input int stall_lo,
                          input int stall_hi, input bit hold, input int repulse_at,
                          input logic [5:0] s2, input int rst_at, input int budget);
      @(posedge CLK); #1;
      while (cyc % div != div - 1) begin
         tick16 = (cyc % div == 0);
         @(posedge CLK); #1;
      end
      t0 = cyc;
      rx_q.delete();
      rx_ferr  = 0;
      done_off = -1;
      n_done   = 0;
      sum      = s;
      start    = 1'b1;
      tick16   = (cyc % div == 0);
      for (int off = 1; off <= budget; off++) begin
         @(posedge CLK); #1;
         start = hold || (off == repulse_at);
         if (off == repulse_at) sum = s2;
         RST    = (off == rst_at);
         tick16 = (cyc % div == 0) && !(off >= stall_lo && off <= stall_hi);
         @(negedge CLK);
         tr_txd[off]  = TXD;
         tr_busy[off] = busy;
         if (done === 1'b1) begin
            n_done++;
            if (done_off < 0) done_off = off;
         end
      end
      start = 1'b0;
      RST   = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) begin
         @(posedge CLK); #1;
         tick16 = 1'b1;
      end
      @(negedge CLK);
      total_cnt++;
      if (TXD !== 1'b1) $display("FAIL reset_txd: got %b, expected 1", TXD); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b, expected 0", done); else pass_cnt++;
      @(posedge CLK); #1;
      RST = 1'b0;
      idle(20);
      @(negedge CLK);
      total_cnt++;
      if (TXD !== 1'b1) $display("FAIL idle_tick_txd: got %b, expected 1", TXD); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL idle_tick_busy: got %b, expected 0", busy); else pass_cnt++;
   endtask

   task automatic test_plus7();
      int low_len, fall;
      run_msg(6'd7, 1, -1, -2, 1'b0, -1, 6'd0, -1, 820);
      low_len = 0;
      for (int i = 1; i <= 820 && tr_txd[i] === 1'b0; i++) low_len++;
      fall = -1;
      for (int i = 1; i <= 820; i++)
         if (fall < 0 && tr_busy[i] === 1'b0) fall = i;
      $display("msg +7: t0=%0d done_off=%0d bytes=%h", t0, done_off, pack5(0));
      total_cnt++;
      if (low_len != 16) $display("FAIL p7_start_len: got %0d, expected 16", low_len); else pass_cnt++;
      total_cnt++;
      if (tr_busy[1] !== 1'b1) $display("FAIL p7_busy_t1: got %b, expected 1", tr_busy[1]); else pass_cnt++;
      total_cnt++;
      if (done_off != 800) $display("FAIL p7_done_off: got %0d, expected 800", done_off); else pass_cnt++;
      total_cnt++;
      if (fall != 800) $display("FAIL p7_busy_fall: got %0d, expected 800", fall); else pass_cnt++;
      total_cnt++;
      if (n_done != 1) $display("FAIL p7_done_count: got %0d, expected 1", n_done); else pass_cnt++;
      total_cnt++;
      if (pack5(0) !== 40'h2B30370D0A || rx_ferr != 0)
         $display("FAIL p7_bytes: got %h ferr=%0d, expected 2b30370d0a ferr=0", pack5(0), rx_ferr);
      else pass_cnt++;
      total_cnt++;
      if (tr_txd[810] !== 1'b1) $display("FAIL p7_idle_txd: got %b, expected 1", tr_txd[810]); else pass_cnt++;
   endtask

   task automatic test_digits();
      logic [5:0]  sums [4];
      logic [39:0] exps [4];
      sums = '{6'h2E, 6'h20, 6'h00, 6'h1F};
      exps = '{40'h2D31380D0A, 40'h2D33320D0A, 40'h2B30300D0A, 40'h2B33310D0A};
      for (int k = 0; k < 4; k++) begin
         run_msg(sums[k], 1, -1, -2, 1'b0, -1, 6'd0, -1, 805);
         $display("msg sum=%0d: done_off=%0d bytes=%h", $signed(sums[k]), done_off, pack5(0));
         total_cnt++;
         if (pack5(0) !== exps[k] || rx_ferr != 0)
            $display("FAIL digits_bytes[%0d]: got %h ferr=%0d, expected %h", k, pack5(0), rx_ferr, exps[k]);
         else pass_cnt++;
         total_cnt++;
         if (done_off != 800) $display("FAIL digits_done[%0d]: got %0d, expected 800", k, done_off); else pass_cnt++;
      end
   endtask

   task automatic test_ignore_restart();
      run_msg(6'h2E, 1, -1, -2, 1'b0, 50, 6'h19, -1, 820);
      $display("msg -18 with repulse: done_off=%0d n_done=%0d bytes=%h", done_off, n_done, pack5(0));
      total_cnt++;
      if (pack5(0) !== 40'h2D31380D0A || rx_q.size() != 5)
         $display("FAIL restart_bytes: got %h n=%0d, expected 2d31380d0a n=5", pack5(0), rx_q.size());
      else pass_cnt++;
      total_cnt++;
      if (n_done != 1) $display("FAIL restart_done_count: got %0d, expected 1", n_done); else pass_cnt++;
      total_cnt++;
      if (done_off != 800) $display("FAIL restart_done_off: got %0d, expected 800", done_off); else pass_cnt++;
   endtask

   task automatic test_slow_tick();
      int low_len, next_low;
      run_msg(6'd7, 4, -1, -2, 1'b0, -1, 6'd0, -1, 3210);
      low_len = 0;
      for (int i = 1; i <= 3210 && tr_txd[i] === 1'b0; i++) low_len++;
      next_low = -1;
      for (int i = 62; i <= 3210; i++)
         if (next_low < 0 && tr_txd[i] === 1'b0) next_low = i;
      $display("msg +7 tick/4: done_off=%0d start_len=%0d bit2_at=%0d", done_off, low_len, next_low);
      total_cnt++;
      if (low_len != 61) $display("FAIL slow_start_len: got %0d, expected 61", low_len); else pass_cnt++;
      total_cnt++;
      if (next_low != 190) $display("FAIL slow_bit_period: got %0d, expected 190", next_low); else pass_cnt++;
      total_cnt++;
      if (done_off != 3197) $display("FAIL slow_done_off: got %0d, expected 3197", done_off); else pass_cnt++;
      total_cnt++;
      if (pack5(0) !== 40'h2B30370D0A) $display("FAIL slow_bytes: got %h, expected 2b30370d0a", pack5(0)); else pass_cnt++;
   endtask

   task automatic test_stall();
      run_msg(6'd7, 1, 200, 299, 1'b0, -1, 6'd0, -1, 920);
      $display("msg +7 stalled 100: done_off=%0d bytes=%h", done_off, pack5(0));
      total_cnt++;
      if (done_off != 900) $display("FAIL stall_done_off: got %0d, expected 900", done_off); else pass_cnt++;
      total_cnt++;
      if (tr_txd[250] !== 1'b0 || tr_busy[250] !== 1'b1)
         $display("FAIL stall_hold: got txd=%b busy=%b, expected txd=0 busy=1", tr_txd[250], tr_busy[250]);
      else pass_cnt++;
      total_cnt++;
      if (pack5(0) !== 40'h2B30370D0A) $display("FAIL stall_bytes: got %h, expected 2b30370d0a", pack5(0)); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int zeros;
      run_msg(6'h1F, 1, -1, -2, 1'b0, -1, 6'd0, 400, 900);
      zeros = 0;
      for (int i = 401; i <= 900; i++) if (tr_txd[i] !== 1'b1) zeros++;
      $display("msg +31 reset at 400: n_done=%0d txd_low_after=%0d", n_done, zeros);
      total_cnt++;
      if (tr_txd[401] !== 1'b1) $display("FAIL rstmid_txd: got %b, expected 1", tr_txd[401]); else pass_cnt++;
      total_cnt++;
      if (tr_busy[401] !== 1'b0) $display("FAIL rstmid_busy: got %b, expected 0", tr_busy[401]); else pass_cnt++;
      total_cnt++;
      if (n_done != 0) $display("FAIL rstmid_no_done: got %0d, expected 0", n_done); else pass_cnt++;
      total_cnt++;
      if (zeros != 0) $display("FAIL rstmid_line_idle: got %0d low cycles, expected 0", zeros); else pass_cnt++;
      run_msg(6'd5, 1, -1, -2, 1'b0, -1, 6'd0, -1, 820);
      $display("msg +5 after reset: done_off=%0d bytes=%h", done_off, pack5(0));
      total_cnt++;
      if (pack5(0) !== 40'h2B30350D0A || rx_ferr != 0)
         $display("FAIL rstmid_next_bytes: got %h ferr=%0d, expected 2b30350d0a ferr=0", pack5(0), rx_ferr);
      else pass_cnt++;
   endtask

   task automatic test_rst_start();
      @(posedge CLK); #1;
      RST    = 1'b1;
      start  = 1'b1;
      sum    = 6'd9;
      tick16 = 1'b1;
      @(posedge CLK); #1;
      RST   = 1'b0;
      start = 1'b0;
      @(negedge CLK);
      $display("rst+start same cycle: busy=%b txd=%b", busy, TXD);
      total_cnt++;
      if (busy !== 1'b0 || TXD !== 1'b1)
         $display("FAIL rst_start: got busy=%b txd=%b, expected busy=0 txd=1", busy, TXD);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      run_msg(6'h3B, 1, -1, -2, 1'b1, -1, 6'd0, -1, 1605);
      $display("b2b -5: done_off=%0d n_done=%0d m0=%h m1=%h", done_off, n_done, pack5(0), pack5(5));
      total_cnt++;
      if (done_off != 800 || n_done != 2)
         $display("FAIL b2b_done: got off=%0d n=%0d, expected off=800 n=2", done_off, n_done);
      else pass_cnt++;
      total_cnt++;
      if (tr_busy[800] !== 1'b0) $display("FAIL b2b_busy_gap: got %b, expected 0", tr_busy[800]); else pass_cnt++;
      total_cnt++;
      if (tr_txd[801] !== 1'b0 || tr_busy[801] !== 1'b1)
         $display("FAIL b2b_restart: got txd=%b busy=%b, expected txd=0 busy=1", tr_txd[801], tr_busy[801]);
      else pass_cnt++;
      total_cnt++;
      if (tr_txd[1601] !== 1'b0) $display("FAIL b2b_third_start: got %b, expected 0", tr_txd[1601]); else pass_cnt++;
      total_cnt++;
      if (pack5(0) !== 40'h2D30350D0A || pack5(5) !== 40'h2D30350D0A || rx_ferr != 0)
         $display("FAIL b2b_bytes: got %h %h ferr=%0d, expected 2d30350d0a twice ferr=0",
                  pack5(0), pack5(5), rx_ferr);
      else pass_cnt++;
      idle(820);
   endtask

   initial begin
      test_reset();
      test_plus7();
      test_digits();
      test_ignore_restart();
      test_slow_tick();
      test_stall();
      test_reset_mid();
      test_rst_start();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/lab4_answer_tx.md
# lab4_answer_tx

Transmit-side counterpart to the lab4 serial receive path. It accepts the signed sum from the lab4 datapath and formats it as five ASCII characters: sign, tens digit, ones digit, CR, LF. It then serializes them as 8N1 UART frames on `TXD`, timed by a single-cycle 16x-baud strike. It sits between `lab4DataPath` (`displayAnswer`/sum) and the board `TXD` pin, and shares the 16x tick that feeds the receiver.

## Interface
Parameters:
- `OVERSAMPLE`, 16, tick strobes per bit period
- `SUM_W`, 6, width of two's-complement `sum` (range −32..+31)

Ports:
- `CLK`  in  1  system clock; all logic on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `tick16`  in  1  one-`CLK`-cycle strobe at 16× baud (9600 b/s → 153.6 kHz)
- `start`  in  1  request to transmit `sum`; sampled only when `busy`=0
- `sum`  in  `SUM_W`  signed result to send; captured on accepted `start`
- `busy`  out  1  high from cycle after accepted `start` until last stop bit ends
- `done`  out  1  one-cycle pulse when the message completes
- `TXD`  out  1  serial line, idle high

## Operation
- Reset values: `TXD`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- Accept: `start`=1 while `busy`=0 captures `sum`.
  - mag = |sum|, 6-bit unsigned (−32 → 32).
  - tens = mag/10 (0..3); ones = mag − 10·tens.
  - Use compare/subtract only; no divider.
- Character sequence, always 5 bytes:
  1. `'-'` 0x2D if sum<0, else `'+'` 0x2B (zero is `+`)
  2. 0x30+tens
  3. 0x30+ones
  4. 0x0D
  5. 0x0A
- Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts `OVERSAMPLE` `tick16` strobes.
- Formatter FSM states, with transitions:
  - IDLE → SIGN on accept.
  - SIGN → TENS → ONES → CR → LF, each advancing when the serializer reports byte complete.
  - LF → IDLE on byte complete, with `done`=1 for that cycle.
- Serializer FSM: IDLE → STARTB → DATA(bit 0..7) → STOPB → IDLE, or back to STARTB if another byte is pending.
- `start` while `busy`=1 is ignored, with no queueing.
- `tick16` in IDLE is ignored. The tick counter clears on every byte load.
- `sum` changes after capture have no effect on the message in flight.

## Timing
- Accepted `start` at cycle t: `busy`=1 and `TXD`=0 (start bit) at t+1.
- Bit change point: the clock edge following the 16th `tick16` of the current bit.
- No idle gap between bytes. The next start bit follows the previous stop bit's 16th tick directly.
- Total message: 5×10×16 = 800 ticks.
- After the 16th tick of the final stop bit: `busy`=0 and `done`=1 in the same cycle. `TXD` stays 1.
- `start` asserted in the cycle `done` pulses is accepted, because `busy`=0. The new start bit appears the next cycle.
- `tick16` held low stalls all bit timing; `TXD` holds its current level.
- `RST` mid-message: next cycle `TXD`=1, `busy`=0, no `done` pulse, and the captured sum is discarded.
- `RST` and `start` in the same cycle: reset wins.

## Structure
- Shared package `lab4_pkg`:
  - ASCII constants (PLUS, MINUS, ZERO, CR, LF)
  - formatter and serializer state encodings
  - `OVERSAMPLE` default
- One sub-module: `uart_tx_byte`.
  - Ports: `CLK`, `RST`, `tick16`, `load`, `din[7:0]`, `ready`, `byte_done`, `TXD`.
  - It owns the bit and tick counters and the shift register.
- The top level holds the sum capture, digit split and formatter FSM.

## Test plan
- `tick16` every cycle, sum=+7, pulse `start` → `TXD` bytes 2B 30 37 0D 0A.
  - Check: start bit low exactly 16 cycles beginning at t+1.
  - Check: `done` at cycle t+800, `busy` falls at t+800.
- sum=−18 → 2D 31 38 0D 0A. sum=−32 → 2D 33 32 0D 0A. sum=0 → 2B 30 30 0D 0A. sum=+31 → 2B 33 31 0D 0A.
- `start` re-pulsed at t+50 with a different `sum` → ignored; original bytes unchanged and a single `done`.
- `tick16` every 4th cycle → each bit lasts 64 cycles. Holding `tick16` low for 100 cycles mid-bit delays all later edges by 100.
- `RST` during the ONES byte data bits → `TXD`=1 and `busy`=0 the next cycle, no `done`. A following `start` with sum=+5 sends a clean 2B 30 35 0D 0A.
- `start` held high continuously → back-to-back messages. Each new message's start bit occurs the cycle after `done`; the receiver loopback decodes all bytes.
